// File: rtl/decoder_output_arbiter_pkg.sv
// Shared definitions for the decoder output arbiter: FSM state encoding,
// tag-byte format and the source-id width helper.
package decoder_output_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_TAG  = 2'd1,
        ARB_FWD  = 2'd2
    } arb_state_t;

    localparam int TAG_W = 8;

    function automatic int id_width(input int num_sources);
        return (num_sources > 1) ? $clog2(num_sources) : 1;
    endfunction

    // Tag byte carries the source id in the low bits, upper bits zero.
    function automatic logic [TAG_W-1:0] tag_byte(input int unsigned id);
        return TAG_W'(id);
    endfunction

endpackage

// File: rtl/decoder_output_arbiter_if.sv
// Byte-stream bundle between the decoder controllers, the arbiter and the host link.
// master = arbiter side, slave = controllers plus host link.
interface decoder_output_arbiter_if #(
    parameter int NUM_SOURCES = 4
);
    logic [8*NUM_SOURCES-1:0] in_data;
    logic [NUM_SOURCES-1:0]   in_valid;
    logic [NUM_SOURCES-1:0]   in_ready;
    logic [7:0]               out_data;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

    modport slave (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );
endinterface

// File: rtl/decoder_output_arbiter_rr_priority_picker.sv
// Round-robin pick: rotate requests so the slot after 'last' is bit 0,
// take the lowest set bit, then map the offset back to a source index.
module rr_priority_picker #(
    parameter int NUM_SOURCES = 4,
    parameter int ID_W        = 2
) (
    input  logic [NUM_SOURCES-1:0] req,
    input  logic [ID_W-1:0]        last,
    output logic [ID_W-1:0]        pick,
    output logic                   any
);
    logic [2*NUM_SOURCES-1:0] req_dbl;
    logic [NUM_SOURCES-1:0]   rotated;
    int unsigned              base;
    int unsigned              offset;
    int unsigned              sum;

    always_comb begin
        req_dbl = {req, req};
        base    = 32'(last) + 32'd1;
        if (base >= NUM_SOURCES) begin
            base = 32'd0;
        end
        rotated = NUM_SOURCES'(req_dbl >> base);

        any    = 1'b0;
        offset = 32'd0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                any    = 1'b1;
                offset = 32'(i);
            end
        end

        sum = base + offset;
        if (sum >= NUM_SOURCES) begin
            sum = sum - 32'(NUM_SOURCES);
        end
        pick = ID_W'(sum);
    end
endmodule

// File: rtl/decoder_output_arbiter.sv
// Shares one byte-wide host link among several decoder controllers, granting
// whole fixed-length packets round-robin with an optional source-tag byte.
//
// state    | meaning
// ARB_IDLE | no grant; picks the next requester (one-cycle bubble)
// ARB_TAG  | presenting the source tag byte of the granted source
// ARB_FWD  | passing the granted source's packet bytes through to the link
module decoder_output_arbiter
    import decoder_output_arbiter_pkg::*;
#(
    parameter  int NUM_SOURCES  = 4,
    parameter  int PACKET_BYTES = 12,
    parameter  int TAG_ENABLE   = 1,
    localparam int ID_W         = id_width(NUM_SOURCES),
    localparam int CNT_W        = $clog2(PACKET_BYTES + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    decoder_output_arbiter_if.master      link,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy,
    output logic [15:0]                   packets_sent
);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PACKET_BYTES - 1);

    arb_state_t       state;
    logic [CNT_W-1:0] byte_cnt;
    logic [ID_W-1:0]  pick_id;
    logic             pick_any;
    logic             fwd_xfer;

    rr_priority_picker #(
        .NUM_SOURCES(NUM_SOURCES),
        .ID_W       (ID_W)
    ) u_picker (
        .req (link.in_valid),
        .last(grant_id),
        .pick(pick_id),
        .any (pick_any)
    );

    assign fwd_xfer = (state == ARB_FWD) && link.out_valid && link.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ARB_IDLE;
            grant_id     <= ID_W'(NUM_SOURCES - 1);
            byte_cnt     <= '0;
            packets_sent <= 16'd0;
            busy         <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        grant_id <= pick_id;
                        byte_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= (TAG_ENABLE != 0) ? ARB_TAG : ARB_FWD;
                    end
                end
                ARB_TAG: begin
                    if (link.out_ready) begin
                        state <= ARB_FWD;
                    end
                end
                ARB_FWD: begin
                    if (fwd_xfer) begin
                        if (byte_cnt == LAST_BYTE) begin
                            packets_sent <= packets_sent + 16'd1;
                            byte_cnt     <= '0;
                            busy         <= 1'b0;
                            state        <= ARB_IDLE;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Forwarding is a straight mux so a packet streams at one byte per cycle.
    always_comb begin
        link.out_valid = 1'b0;
        link.out_data  = 8'h00;
        link.in_ready  = '0;
        case (state)
            ARB_TAG: begin
                link.out_valid = 1'b1;
                link.out_data  = tag_byte(32'(grant_id));
            end
            ARB_FWD: begin
                for (int i = 0; i < NUM_SOURCES; i++) begin
                    if (ID_W'(i) == grant_id) begin
                        link.out_data    = link.in_data[8*i +: 8];
                        link.out_valid   = link.in_valid[i];
                        link.in_ready[i] = link.out_ready;
                    end
                end
            end
            default: begin
            end
        endcase
    end
endmodule

// File: tb/tb_decoder_output_arbiter.sv
// Randomised scoreboard bench for decoder_output_arbiter: a tagged 4-source
// instance checked against a packet-level round-robin model, plus an untagged instance.
module tb_decoder_output_arbiter;
    localparam int NS   = 4;
    localparam int PB   = 12;
    localparam int TAG  = 1;
    localparam int PB2  = 2;
    localparam int NPK2 = 30;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic reset2 = 1'b1;
    always #5 clk = ~clk;

    decoder_output_arbiter_if #(.NUM_SOURCES(NS)) link ();
    decoder_output_arbiter_if #(.NUM_SOURCES(NS)) link2 ();

    logic [1:0]  grant_id, grant_id2;
    logic        busy, busy2;
    logic [15:0] packets_sent, packets_sent2;

    decoder_output_arbiter #(.NUM_SOURCES(NS), .PACKET_BYTES(PB), .TAG_ENABLE(TAG)) dut (
        .clk(clk), .reset(reset), .link(link),
        .grant_id(grant_id), .busy(busy), .packets_sent(packets_sent)
    );

    decoder_output_arbiter #(.NUM_SOURCES(NS), .PACKET_BYTES(PB2), .TAG_ENABLE(0)) dut2 (
        .clk(clk), .reset(reset2), .link(link2),
        .grant_id(grant_id2), .busy(busy2), .packets_sent(packets_sent2)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input bit ok, input string name, input int act, input int req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // source packet storage: drv_q feeds the drivers, mdl_q feeds the model
    logic [7:0] drv_q [NS][$];
    logic [7:0] mdl_q [NS][$];
    logic [7:0] exp_q [$];
    int         tag_log [$];
    logic [7:0] q2 [$];

    int stall_pct  = 0;
    int ready_mode = 2;
    int ready_pct  = 70;

    bit          m_idle      = 1'b1;
    int          m_last      = NS - 1;
    int          m_rem       = 0;
    bit          m_tag_phase = 1'b0;
    logic [15:0] m_pkts      = 16'd0;
    int          busy_cycles = 0;
    bit          post_reset  = 1'b0;
    bit          d2_done     = 1'b0;

    function automatic int rr_next(input int last, input logic [NS-1:0] req);
        int c;
        for (int k = 1; k <= NS; k++) begin
            c = (last + k) % NS;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    function automatic bit all_empty();
        for (int s = 0; s < NS; s++) if (drv_q[s].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic add_packet(input int s, input bit seq, input int first);
        logic [7:0] b;
        for (int i = 0; i < PB; i++) begin
            b = seq ? 8'(first + i) : 8'($urandom);
            drv_q[s].push_back(b);
            mdl_q[s].push_back(b);
        end
    endtask

    task automatic sync_add();
        @(negedge clk);
        #2;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (n < 4000 && !(all_empty() && m_idle && exp_q.size() == 0)) begin
            @(posedge clk);
            n++;
        end
        check(n < 4000, {name, "_drain"}, n, 4000);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin : driver
        logic [NS-1:0] acc;
        bit            rst_seen;
        bit            tog;
        link.in_valid  = '0;
        link.in_data   = '0;
        link.out_ready = 1'b0;
        tog            = 1'b0;
        forever begin
            @(negedge clk);
            acc      = link.in_valid & link.in_ready;
            rst_seen = reset;
            @(posedge clk); #1;
            for (int s = 0; s < NS; s++) begin
                if (rst_seen) drv_q[s].delete();
                else if (acc[s] && drv_q[s].size() > 0) void'(drv_q[s].pop_front());
                if (drv_q[s].size() > 0 && int'($urandom_range(99)) >= stall_pct) begin
                    link.in_valid[s]       = 1'b1;
                    link.in_data[8*s +: 8] = drv_q[s][0];
                end else begin
                    link.in_valid[s]       = 1'b0;
                    link.in_data[8*s +: 8] = 8'h00;
                end
            end
            tog = !tog;
            case (ready_mode)
                0:       link.out_ready = (int'($urandom_range(99)) < ready_pct);
                1:       link.out_ready = tog;
                default: link.out_ready = 1'b1;
            endcase
        end
    end

    initial begin : monitor
        logic [7:0]    exp_b;
        logic [NS-1:0] exp_rdy;
        int            pick;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                for (int s = 0; s < NS; s++) mdl_q[s].delete();
                m_idle      = 1'b1;
                m_last      = NS - 1;
                m_rem       = 0;
                m_tag_phase = 1'b0;
                m_pkts      = 16'd0;
                post_reset  = 1'b1;
                continue;
            end
            if (post_reset) begin
                post_reset = 1'b0;
                check(link.out_valid == 1'b0, "reset_out_valid", int'(link.out_valid), 0);
                check(link.in_ready == '0, "reset_in_ready", int'(link.in_ready), 0);
                check(link.out_data == 8'h00, "reset_out_data", int'(link.out_data), 0);
                check(int'(grant_id) == NS - 1, "reset_grant_id", int'(grant_id), NS - 1);
                check(packets_sent == 16'd0, "reset_packets_sent", int'(packets_sent), 0);
            end
            check(busy == !m_idle, "busy", int'(busy), int'(!m_idle));
            check(packets_sent == m_pkts, "packets_sent", int'(packets_sent), int'(m_pkts));
            if (busy) busy_cycles++;
            if (m_idle) begin
                check(!link.out_valid && link.in_ready == '0, "idle_quiet",
                      int'({link.out_valid, link.in_ready}), 0);
                if (link.in_valid != '0) begin
                    pick        = rr_next(m_last, link.in_valid);
                    m_last      = pick;
                    m_idle      = 1'b0;
                    m_tag_phase = (TAG != 0);
                    m_rem       = PB + TAG;
                    if (TAG != 0) exp_q.push_back(8'(pick));
                    for (int i = 0; i < PB; i++) begin
                        if (mdl_q[pick].size() == 0) check(1'b0, "model_source_empty", pick, -1);
                        else exp_q.push_back(mdl_q[pick].pop_front());
                    end
                end
            end else begin
                check(int'(grant_id) == m_last, "grant_id", int'(grant_id), m_last);
                if (m_tag_phase) begin
                    check(link.out_valid && link.in_ready == '0, "tag_phase",
                          int'({link.out_valid, link.in_ready}), 16);
                end else begin
                    exp_rdy = link.out_ready ? (NS'(1) << m_last) : '0;
                    check(link.out_valid == link.in_valid[m_last], "fwd_out_valid",
                          int'(link.out_valid), int'(link.in_valid[m_last]));
                    check(link.in_ready == exp_rdy, "fwd_in_ready", int'(link.in_ready), int'(exp_rdy));
                end
                if (link.out_valid && link.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_byte", int'(link.out_data), -1);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check(link.out_data == exp_b, m_tag_phase ? "tag_byte" : "data_byte",
                              int'(link.out_data), int'(exp_b));
                    end
                    if (m_tag_phase) tag_log.push_back(int'(link.out_data));
                    m_tag_phase = 1'b0;
                    m_rem--;
                    if (m_rem == 0) begin
                        m_idle = 1'b1;
                        m_pkts = m_pkts + 16'd1;
                    end
                end
            end
        end
    end

    // untagged instance: one source streaming, bytes pushed as they are presented
    initial begin : dut2_driver
        int         presented;
        int         n;
        bit         acc;
        logic [7:0] b;
        link2.in_valid  = '0;
        link2.in_data   = '0;
        link2.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset2 = 1'b0;
        @(posedge clk); #1;
        b = 8'h40;
        link2.in_valid[1]   = 1'b1;
        link2.in_data[15:8] = b;
        q2.push_back(b);
        presented = 1;
        n = 0;
        while (n < 1000 && (presented < PB2 * NPK2 || link2.in_valid[1])) begin
            @(negedge clk);
            acc = link2.in_valid[1] && link2.in_ready[1];
            @(posedge clk); #1;
            n++;
            link2.out_ready = ($urandom_range(99) < 80);
            if (acc) begin
                if (presented < PB2 * NPK2) begin
                    b = 8'(8'h40 + presented);
                    link2.in_data[15:8] = b;
                    q2.push_back(b);
                    presented++;
                end else begin
                    link2.in_valid[1]   = 1'b0;
                    link2.in_data[15:8] = 8'h00;
                end
            end
        end
        check(n < 1000, "dut2_stream_timeout", n, 1000);
        repeat (4) @(posedge clk);
        #1;
        check(packets_sent2 == 16'(NPK2), "dut2_packets_sent", int'(packets_sent2), NPK2);
        check(q2.size() == 0, "dut2_bytes_left", q2.size(), 0);
        check(busy2 == 1'b0, "dut2_busy_end", int'(busy2), 0);
        d2_done = 1'b1;
    end

    initial begin : dut2_monitor
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!reset2 && link2.out_valid && link2.out_ready) begin
                if (q2.size() == 0) begin
                    check(1'b0, "dut2_unexpected_byte", int'(link2.out_data), -1);
                end else begin
                    e = q2.pop_front();
                    check(link2.out_data == e, "dut2_byte", int'(link2.out_data), int'(e));
                end
                check(grant_id2 == 2'd1, "dut2_grant", int'(grant_id2), 1);
            end
        end
    end

    initial begin : main
        int n;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // single source, sequential bytes, always ready
        ready_mode = 2; stall_pct = 0;
        tag_log.delete();
        busy_cycles = 0;
        sync_add();
        add_packet(2, 1'b1, 1);
        drain("single_src");
        check(tag_log.size() == 1 && tag_log[0] == 2, "single_src_tag",
              tag_log.size() > 0 ? tag_log[0] : -1, 2);
        check(busy_cycles == PB + TAG, "single_src_busy_cycles", busy_cycles, PB + TAG);
        check(packets_sent == 16'd1, "single_src_packets", int'(packets_sent), 1);

        // all four sources continuously valid from reset
        pulse_reset();
        tag_log.delete();
        sync_add();
        for (int r = 0; r < 2; r++) for (int s = 0; s < NS; s++) add_packet(s, 1'b0, 0);
        drain("all_valid");
        check(tag_log.size() == 2 * NS, "all_valid_tag_count", tag_log.size(), 2 * NS);
        for (int i = 0; i < tag_log.size(); i++)
            check(tag_log[i] == i % NS, "all_valid_tag_order", tag_log[i], i % NS);

        // out_ready toggling every cycle
        ready_mode = 1;
        sync_add();
        add_packet(1, 1'b1, 8'hA0);
        drain("ready_toggle");

        // random traffic with source stalls and host back-pressure
        ready_mode = 0; stall_pct = 25;
        for (int k = 0; k < 40; k++) begin
            sync_add();
            add_packet(int'($urandom_range(NS - 1)), 1'b0, 0);
            repeat ($urandom_range(15)) @(posedge clk);
        end
        drain("random_traffic");

        // reset in the middle of a src1 packet, then src0 must win
        ready_mode = 2; stall_pct = 0;
        sync_add();
        add_packet(1, 1'b1, 8'h30);
        n = 0;
        while (n < 500 && !(!m_idle && m_last == 1 && m_rem == PB + TAG - 7)) begin
            @(posedge clk);
            n++;
        end
        check(n < 500, "mid_packet_wait", n, 500);
        pulse_reset();
        tag_log.delete();
        sync_add();
        add_packet(2, 1'b0, 0);
        add_packet(0, 1'b0, 0);
        drain("after_reset");
        check(tag_log.size() == 2 && tag_log[0] == 0, "after_reset_first_grant",
              tag_log.size() > 0 ? tag_log[0] : -1, 0);

        n = 0;
        while (n < 2000 && !d2_done) begin
            @(posedge clk);
            n++;
        end
        check(d2_done, "dut2_done_wait", n, 2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
